// File: rtl/axi_iic_lite_master.sv
// AXI4-Lite initiator for the IIC controller register port.
// Turns a one-at-a-time command/response handshake into a single AXI-Lite
// write (AW/W/B) or read (AR/R) transaction.
// Optional build macro AXI_IIC_MST_TIMEOUT_EN adds a per-transaction timeout
// that answers SLVERR and then locks the master in HALT until reset.
module axi_iic_lite_master #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE, WR, WR_B, RD_A, RD_R, RSP
`ifdef AXI_IIC_MST_TIMEOUT_EN
    , HALT
`endif
  } state_t;

  state_t                state, next;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  aw_done, w_done;
  logic                  accept, aw_hs, w_hs, capture_b, capture_r, expire;

  // Payload registers drive the AXI address/data lines directly, so they stay
  // stable for the whole time the matching valid is high.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;

`ifdef AXI_IIC_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             tmo_q;
  logic             busy;

  assign busy        = (state == WR) || (state == WR_B) || (state == RD_A) || (state == RD_R);
  assign rsp_timeout = tmo_q;

  // Transaction watchdog: cleared on acceptance, counts busy cycles, saturates.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (busy && (cnt < CNT_W'(TIMEOUT_CYCLES))) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign rsp_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= next;
  end

  // Next-state and bus handshake outputs; valids depend on state only.
  always_comb begin
    next          = state;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    accept        = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    capture_b     = 1'b0;
    capture_r     = 1'b0;
    expire        = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          next   = cmd_write ? WR : RD_A;
        end
      end
      WR: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        aw_hs         = m_axi_awvalid && m_axi_awready;
        w_hs          = m_axi_wvalid && m_axi_wready;
        if ((aw_done || aw_hs) && (w_done || w_hs)) next = WR_B;
      end
      WR_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          capture_b = 1'b1;
          next      = RSP;
        end
      end
      RD_A: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) next = RD_R;
      end
      RD_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          capture_r = 1'b1;
          next      = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
`ifdef AXI_IIC_MST_TIMEOUT_EN
          next = tmo_q ? HALT : IDLE;
`else
          next = IDLE;
`endif
        end
      end
`ifdef AXI_IIC_MST_TIMEOUT_EN
      HALT: next = HALT;
`endif
      default: next = IDLE;
    endcase
`ifdef AXI_IIC_MST_TIMEOUT_EN
    // A handshake that moves the state on in the limit cycle takes priority.
    if (busy && (next == state) && (cnt >= CNT_W'(TIMEOUT_CYCLES - 1))) begin
      expire = 1'b1;
      next   = RSP;
    end
`endif
  end

  // Command capture, per-channel write progress and response registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
`ifdef AXI_IIC_MST_TIMEOUT_EN
      tmo_q     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (capture_b) begin
        rsp_rdata <= '0;
        rsp_resp  <= m_axi_bresp;
      end
      if (capture_r) begin
        rsp_rdata <= m_axi_rdata;
        rsp_resp  <= m_axi_rresp;
      end
`ifdef AXI_IIC_MST_TIMEOUT_EN
      if (capture_b || capture_r) tmo_q <= 1'b0;
      if (expire) begin
        rsp_rdata <= '0;
        rsp_resp  <= 2'b10;
        tmo_q     <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: doc/axi_iic_lite_master.md
Name: axi_iic_lite_master

Overview:
- AXI4-Lite initiator that drives register accesses into the IIC controller's 9-bit AXI-Lite slave port.
- Converts a simple one-at-a-time command/response interface into AXI-Lite write (AW/W/B) or read (AR/R) transactions.
- Used by on-chip sequencers and by the formal/sim bench as the controller's bus master.
- One transaction outstanding at a time. No reordering, no bursts.

Parameters:
- ADDR_W, 9, AXI address width (matches the controller register space).
- DATA_W, 32, AXI data width; the strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 256, cycle limit per transaction. Used only when AXI_IIC_MST_TIMEOUT_EN is defined.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  register byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  AXI BRESP/RRESP, or SLVERR on timeout
- rsp_timeout  out  1  response produced by timeout
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master side, widths per parameters. m_axi_awprot/arprot are not provided.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0. All m_axi_*valid, bready and rready are 0. All address/data/strobe outputs are 0.
- Reset asserted mid-transaction: all valids drop immediately; the partial AXI transaction is abandoned.
- States: IDLE, WR, WR_B, RD_A, RD_R, RSP, HALT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture addr/wdata/wstrb. Go to WR if cmd_write, else RD_A.
  - awvalid/wvalid (or arvalid) rise in the cycle after acceptance, i.e. 1-cycle latency.
- WR:
  - awvalid and wvalid are asserted together; each drops independently on its own handshake, tracked by aw_done/w_done flags.
  - When both are done, go to WR_B. This covers same-cycle handshakes and either order.
  - Valid never depends on ready. Payload is stable while valid is high.
- WR_B: bready=1. On bvalid, capture bresp, set rdata=0, go to RSP.
- RD_A: arvalid=1. On arready, go to RD_R.
- RD_R: rready=1. On rvalid, capture rdata/rresp, go to RSP.
- RSP:
  - rsp_valid=1. Outputs are held stable until rsp_ready.
  - On rsp_ready, go to IDLE; cmd_ready returns next cycle.
  - Back-to-back throughput is therefore at least 4 cycles per write and 4 per read with zero-wait slave.
- cmd_ready=0 in every state except IDLE. cmd_valid outside IDLE is ignored.
- bready/rready are asserted only in WR_B/RD_R, never speculatively.
- Slave SLVERR/DECERR responses are passed through unchanged on rsp_resp with rsp_timeout=0.
- HALT is reachable only with the optional feature enabled.

Optional Feature:
- Macro: AXI_IIC_MST_TIMEOUT_EN.
- Defined:
  - A counter clears on command acceptance and increments every cycle in WR/WR_B/RD_A/RD_R.
  - When it reaches TIMEOUT_CYCLES, all valids/readies drop and state goes to RSP with rsp_resp=2'b10, rsp_rdata=0, rsp_timeout=1.
  - After that response is consumed, state goes to HALT: cmd_ready=0 permanently until reset, since the bus is in an unknown state.
  - A handshake that completes in the same cycle the counter hits the limit wins; no timeout is raised.
- Undefined: no counter and no HALT state; rsp_timeout is tied to 0; the block waits indefinitely.

Test Plan:
- Write 0x100 data 0x00000001 strb 0xF, awready 3 cycles before wready:
  - Expect exactly one AW and one W handshake, awaddr=0x100.
  - Expect rsp_resp=0, rsp_rdata=0, rsp_timeout=0.
- Write with AW/W ready in the same cycle, then the W-first ordering:
  - Expect no duplicate handshakes in either case.
  - Expect bready high only after both complete.
- Read 0x104, slave returns rdata=0x000000C0 after 2-cycle rvalid delay:
  - Expect rsp_rdata=0xC0, rsp_resp=0.
  - Expect arvalid held until arready.
- Slave returns BRESP=2'b10; rsp_ready held low 5 cycles:
  - Expect rsp_resp=2'b10 with rsp_valid and data stable for all 5 cycles.
  - Expect cmd_ready=0 throughout those cycles.
- Reset pulsed while in WR with awvalid=1:
  - Expect awvalid/wvalid=0 asynchronously.
  - Expect cmd_ready=1 after release; the next command completes normally.
- With AXI_IIC_MST_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready never asserted:
  - Expect arvalid to drop at cycle 16.
  - Expect rsp_resp=2'b10, rsp_timeout=1.
  - Expect cmd_ready to stay 0 afterwards until reset.
